mem_loader_32kb: RTL and testbench

Sequencer that sits directly upstream of the 32 KB banked byte memory (15-bit address, 8-bit data, single `we`, registered read). It accepts a byte stream over a valid/ready handshake and writes it to consecutive addresses (load), or reads a block of consecutive addresses and streams the bytes out over a valid/ready handshake (dump). It is the only master of the memory port.

---
 rtl/mem_loader_pkg.sv | 30 +++
 rtl/mem_loader_32kb_if.sv | 56 +++++
 rtl/mem_loader_32kb.sv | 134 +++++++++++++
 tb/tb_mem_loader_32kb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the 32 KB memory loader/dumper.
package mem_loader_pkg;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 8;
  localparam int LEN_W     = 16;
  localparam int MEM_BYTES = 32768;

  // Sequencer states; exported on the debug port of the top.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_OUT  = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  // A block can never be larger than the memory, so oversize lengths are
  // clamped when the command is latched.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] lim;
    lim = LEN_W'(MEM_BYTES);
    if (len > lim) begin
      return lim;
    end
    return len;
  endfunction

endpackage

// File: rtl/mem_loader_32kb_if.sv
// Bundle of command, stream and memory-port signals for mem_loader_32kb.
//
// Handshake rule for both byte streams: a byte transfers on a rising edge
// where valid and ready are both 1. A source holding valid keeps its data
// stable and does not drop valid until the transfer happens; ready may
// change freely and never depends combinationally on valid.
interface mem_loader_32kb_if;
  import mem_loader_pkg::*;

  // command
  logic              cmd_load;
  logic              cmd_dump;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  length;
  // load stream (into the loader)
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  // dump stream (out of the loader)
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  // status
  logic              busy;
  logic              done;
  // memory port (loader is the only master)
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Loader side.
  modport slave (
    input  cmd_load, cmd_dump, start_addr, length,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data,
    input  out_ready,
    output busy, done,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  // Host / memory side.
  modport master (
    output cmd_load, cmd_dump, start_addr, length,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data,
    output out_ready,
    input  busy, done,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/mem_loader_32kb.sv
// Load/dump sequencer in front of the 32 KB byte memory. Load writes an
// incoming byte stream to consecutive addresses; dump reads consecutive
// addresses (registered read, one cycle) and streams the bytes out.
module mem_loader_32kb
  import mem_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  mem_loader_32kb_if.slave    bus,
  output state_e              dbg_state
);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q,    mem_we_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;

  logic in_hs;
  logic out_hs;
  logic last_byte;

  assign in_hs     = (state_q == ST_LOAD)   && bus.in_valid;
  assign out_hs    = (state_q == ST_RD_OUT) && bus.out_ready;
  assign last_byte = (remaining_q == LEN_W'(1));

  // Next-state, counter and memory-port computation.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    out_data_d  = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_load || bus.cmd_dump) begin
          cur_addr_d  = bus.start_addr;
          remaining_d = clamp_len(bus.length);
          if (bus.length == '0) begin
            state_d = ST_FIN;
          end else if (bus.cmd_load) begin
            state_d = ST_LOAD;
          end else begin
            // Address is presented during RD_ADDR so read data lands in RD_WAIT.
            state_d    = ST_RD_ADDR;
            mem_addr_d = bus.start_addr;
          end
        end
      end

      ST_LOAD: begin
        if (in_hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cur_addr_q;
          mem_wdata_d = bus.in_data;
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (last_byte) begin
            state_d = ST_FIN;
          end
        end
      end

      ST_RD_ADDR: begin
        mem_addr_d = cur_addr_q;
        state_d    = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        out_data_d = bus.mem_rdata;
        state_d    = ST_RD_OUT;
      end

      ST_RD_OUT: begin
        if (out_hs) begin
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (last_byte) begin
            state_d = ST_FIN;
          end else begin
            state_d    = ST_RD_ADDR;
            mem_addr_d = cur_addr_q + ADDR_W'(1);
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      out_data_q  <= out_data_d;
    end
  end

  // Status and stream controls decode straight from the state register.
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_RD_OUT);
  assign bus.done      = (state_q == ST_FIN);
  assign bus.out_data  = out_data_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_loader_32kb.sv
// Bench for mem_loader_32kb: behavioural memory, event monitor, directed
// and random load/dump sequences checked against a flat byte-array model.
module tb_mem_loader_32kb;
  import mem_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_loader_32kb_if bus ();
  state_e dbg_state;

  mem_loader_32kb dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- memory behind the loader ----------------
  logic [7:0] mem [0:MEM_BYTES-1];
  logic [7:0] model_mem [0:MEM_BYTES-1];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // ---------------- monitor (samples mid-cycle) ----------------
  logic [14:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];
  logic [7:0]  rd_data_q[$];
  int          rd_cyc_q[$];
  int          done_cyc_q[$];

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.out_valid && bus.out_ready) begin
      rd_data_q.push_back(bus.out_data);
      rd_cyc_q.push_back(cyc);
    end
    if (bus.done) done_cyc_q.push_back(cyc);
  end

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] fixed_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_data_q.delete(); rd_cyc_q.delete(); done_cyc_q.delete();
  endtask

  function automatic logic [14:0] addr_at(input logic [14:0] a, input int i);
    return 15'((int'(a) + i) % MEM_BYTES);
  endfunction

  // Load len bytes at a. Data comes from fixed_q if filled, else random.
  task automatic run_load(input string nm, input logic [14:0] a, input int len,
                          input bit both, input bit gaps, input bit poke_dump);
    logic [7:0] data[$];
    int hs_cyc[$];
    int guard;
    logic [7:0] d;
    clear_mon();
    bus.cmd_load = 1'b1; bus.cmd_dump = both;
    bus.start_addr = a; bus.length = 16'(len);
    tick();
    bus.cmd_load = 1'b0; bus.cmd_dump = 1'b0;
    check({nm, "_busy_t1"}, bus.busy, 1);
    check({nm, "_in_ready_t1"}, bus.in_ready, 1);
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      d = (fixed_q.size() > 0) ? fixed_q[i] : 8'($urandom_range(0, 255));
      bus.in_valid = 1'b1; bus.in_data = d;
      if (poke_dump && i == 1) begin
        bus.cmd_dump = 1'b1;
        bus.start_addr = 15'($urandom_range(0, MEM_BYTES - 1));
        bus.length = 16'($urandom_range(1, 9));
      end
      guard = 0;
      while (!bus.in_ready && guard < 10) begin tick(); guard++; end
      if (guard >= 10) begin check({nm, "_in_ready_timeout"}, 0, 1); break; end
      hs_cyc.push_back(cyc); data.push_back(d);
      tick();
      bus.cmd_dump = 1'b0;
    end
    bus.in_valid = 1'b0; bus.in_data = 8'($urandom_range(0, 255));
    repeat (3) tick();
    check({nm, "_in_ready_end"}, bus.in_ready, 0);
    check({nm, "_idle_end"}, bus.busy, 0);
    check({nm, "_wr_count"}, wr_addr_q.size(), data.size());
    for (int i = 0; i < data.size() && i < wr_addr_q.size(); i++) begin
      check({nm, "_wr_addr"}, wr_addr_q[i], addr_at(a, i));
      check({nm, "_wr_data"}, wr_data_q[i], data[i]);
      check({nm, "_wr_lat"}, wr_cyc_q[i], hs_cyc[i] + 1);
      model_mem[addr_at(a, i)] = data[i];
    end
    check({nm, "_done_count"}, done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0 && hs_cyc.size() > 0)
      check({nm, "_done_lat"}, done_cyc_q[0], hs_cyc[hs_cyc.size()-1] + 1);
    fixed_q.delete();
  endtask

  // Dump len bytes from a. mode 0: always ready; 1: random ready;
  // 2: ready held low for 5 cycles while byte 2 is offered.
  task automatic run_dump(input string nm, input logic [14:0] a, input int len, input int mode);
    int t, guard, stall_left;
    bit held;
    logic [7:0] held_data;
    clear_mon();
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(model_mem[addr_at(a, i)]);
    bus.cmd_dump = 1'b1; bus.start_addr = a; bus.length = 16'(len);
    bus.out_ready = (mode != 1);
    t = cyc;
    tick();
    bus.cmd_dump = 1'b0;
    check({nm, "_busy_t1"}, bus.busy, 1);
    held = 1'b0; held_data = '0; guard = 0; stall_left = 5;
    while (!bus.done && guard < len * 20 + 20) begin
      if (held) begin
        check({nm, "_hold_valid"}, bus.out_valid, 1);
        check({nm, "_hold_data"}, bus.out_data, held_data);
      end
      case (mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (bus.out_valid && rd_data_q.size() == 1 && stall_left > 0) begin
            bus.out_ready = 1'b0; stall_left--;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
      endcase
      held = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      tick(); guard++;
    end
    check({nm, "_done_seen"}, bus.done, 1);
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check({nm, "_idle_end"}, bus.busy, 0);
    check({nm, "_rd_count"}, rd_data_q.size(), len);
    for (int i = 0; i < len && i < rd_data_q.size(); i++) begin
      check({nm, "_rd_data"}, rd_data_q[i], exp_q[i]);
      if (mode == 0) check({nm, "_rd_spacing"}, rd_cyc_q[i], t + 3 + 3 * i);
    end
    if (mode == 2 && len >= 2) check({nm, "_stall_applied"}, stall_left, 0);
    check({nm, "_no_we"}, wr_addr_q.size(), 0);
    check({nm, "_done_count"}, done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0 && rd_cyc_q.size() > 0)
      check({nm, "_done_lat"}, done_cyc_q[0], rd_cyc_q[rd_cyc_q.size()-1] + 1);
  endtask

  task automatic run_len0(input string nm, input bit is_load);
    int t, dl;
    clear_mon();
    bus.cmd_load = is_load; bus.cmd_dump = !is_load;
    bus.start_addr = 15'($urandom_range(0, MEM_BYTES - 1)); bus.length = 16'd0;
    t = cyc;
    tick();
    bus.cmd_load = 1'b0; bus.cmd_dump = 1'b0;
    repeat (4) tick();
    check({nm, "_done_count"}, done_cyc_q.size(), 1);
    dl = (done_cyc_q.size() > 0) ? done_cyc_q[0] - t : -1;
    check({nm, "_done_lat"}, (dl == 1 || dl == 2), 1);
    check({nm, "_no_we"}, wr_addr_q.size(), 0);
    check({nm, "_no_out"}, rd_data_q.size(), 0);
    check({nm, "_idle_end"}, bus.busy, 0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_in_ready"}, bus.in_ready, 0);
    check({nm, "_out_valid"}, bus.out_valid, 0);
    check({nm, "_busy"}, bus.busy, 0);
    check({nm, "_done"}, bus.done, 0);
    check({nm, "_mem_we"}, bus.mem_we, 0);
    check({nm, "_mem_addr"}, bus.mem_addr, 0);
    check({nm, "_mem_wdata"}, bus.mem_wdata, 0);
    check({nm, "_out_data"}, bus.out_data, 0);
    check({nm, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [14:0] ra;
    int rl;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i] = 8'($urandom_range(0, 255));
      model_mem[i] = mem[i];
    end
    bus.cmd_load = 0; bus.cmd_dump = 0; bus.start_addr = '0; bus.length = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;

    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Basic load and read-back.
    fixed_q.push_back(8'hA1); fixed_q.push_back(8'hA2);
    fixed_q.push_back(8'hA3); fixed_q.push_back(8'hA4);
    run_load("load4", 15'h0010, 4, 0, 0, 0);
    run_dump("dump4", 15'h0010, 4, 0);

    // Address wrap on load and dump.
    run_load("wrap_load", 15'h7FFE, 3, 0, 0, 0);
    run_dump("wrap_dump", 15'h7FFE, 3, 0);

    // Backpressure on the second byte.
    run_dump("bp_dump", 15'h0010, 4, 2);

    // Zero-length commands.
    run_len0("len0_load", 1);
    run_len0("len0_dump", 0);

    // Simultaneous commands: load wins.
    run_load("both_cmd", 15'h0100, 2, 1, 0, 0);
    run_dump("both_chk", 15'h0100, 2, 0);

    // Dump command during a load is dropped.
    run_load("busy_cmd", 15'h0200, 5, 0, 1, 1);
    check("busy_cmd_no_out", rd_data_q.size(), 0);

    // Reset after 2 of 6 load bytes.
    clear_mon();
    bus.cmd_load = 1'b1; bus.start_addr = 15'h0300; bus.length = 16'd6;
    tick();
    bus.cmd_load = 1'b0;
    fixed_q.push_back(8'h5A); fixed_q.push_back(8'hC3);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_data = fixed_q[i];
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_rst");
    repeat (3) tick();
    check("mid_rst_no_done", done_cyc_q.size(), 0);
    check("mid_rst_wr_count", wr_addr_q.size(), 2);
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      check("mid_rst_wr_addr", wr_addr_q[i], addr_at(15'h0300, i));
      check("mid_rst_wr_data", wr_data_q[i], fixed_q[i]);
      model_mem[addr_at(15'h0300, i)] = fixed_q[i];
    end
    fixed_q.delete();
    run_load("post_rst_load", 15'h0300, 6, 0, 0, 0);
    run_dump("post_rst_dump", 15'h02FE, 10, 0);

    // Random load/dump pairs with random stalls and gaps.
    for (int k = 0; k < 6; k++) begin
      ra = 15'($urandom_range(0, MEM_BYTES - 1));
      rl = $urandom_range(1, 8);
      run_load("rnd_load", ra, rl, 0, 1, 0);
      run_dump("rnd_dump", 15'(int'(ra) + $urandom_range(0, 2)), $urandom_range(1, 8), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
